// File: rtl/vend_dispense_ctrl_pkg.sv
// Shared types, status codes and keypad decode helpers for the vend dispense controller.
package vend_dispense_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StDebounce = 3'd1,
    StArm      = 3'd2,
    StDispense = 3'd3,
    StRelease  = 3'd4,
    StFault    = 3'd5
  } vend_state_e;

  localparam logic [1:0] StatusIdle  = 2'b00;
  localparam logic [1:0] StatusBusy  = 2'b01;
  localparam logic [1:0] StatusDone  = 2'b10;
  localparam logic [1:0] StatusFault = 2'b11;

  // True when exactly one of the three lines is active.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Index of the active line (bit0 = index 0); only meaningful for one-hot input.
  function automatic logic [1:0] onehot_idx(input logic [2:0] v);
    logic [1:0] idx;
    case (v)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Selection code 1..9 = row*3 + col + 1.
  function automatic logic [3:0] key_code(input logic [2:0] col, input logic [2:0] row);
    return ({2'b00, onehot_idx(row)} * 4'd3) + {2'b00, onehot_idx(col)} + 4'd1;
  endfunction

endpackage

// File: rtl/vend_key_debounce.sv
// Keypad validity check and stability counter. The pattern is snapshotted while the FSM is
// idle and counted while the FSM is debouncing.
module vend_key_debounce
  import vend_dispense_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [2:0] col_i,
  input  logic [2:0] row_i,
  output logic       key_valid_o,
  output logic       key_hold_o,
  output logic       key_ok_o,
  output logic [3:0] code_o
);

  logic [2:0]       col_q, col_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Validity, match against the snapshot, and saturating stability count.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = '0;
    key_valid_o = is_onehot3(col_i) && is_onehot3(row_i);
    key_hold_o  = key_valid_o && (col_i == col_q) && (row_i == row_q);
    if (!run_i) begin
      col_d = col_i;
      row_d = row_i;
    end else if (key_hold_o) begin
      cnt_d = (cnt_q == CNT_W'(DEBOUNCE_CYC)) ? cnt_q : cnt_q + 1'b1;
    end
    key_ok_o = run_i && key_hold_o && (cnt_d == CNT_W'(DEBOUNCE_CYC));
    code_o   = key_code(col_q, row_q);
  end

  // Snapshot and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// One vend cycle: debounced key selection, relay drive, drop confirmation, timeout/jam fault.
module vend_dispense_ctrl
  import vend_dispense_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 8,
  parameter int unsigned SENSE_CYC    = 4,
  parameter int unsigned TIMEOUT_CYC  = 2000,
  parameter int unsigned FAULT_HOLD   = 500
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [2:0] coluna_in,
  input  logic [2:0] linha_in,
  input  logic       sensor1_in,
  input  logic       sensor2_in,
  output logic       rele_out,
  output logic [3:0] sel_code_out,
  output logic [1:0] status_out,
  output logic       done_out,
  output logic       fault_out
);

  localparam int unsigned MaxA   = (DEBOUNCE_CYC > SENSE_CYC) ? DEBOUNCE_CYC : SENSE_CYC;
  localparam int unsigned MaxB   = (TIMEOUT_CYC > FAULT_HOLD) ? TIMEOUT_CYC : FAULT_HOLD;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  vend_state_e     state_q, state_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic [CntW-1:0] sense_q, sense_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            rele_q, rele_d;
  logic [3:0]      sel_q, sel_d;
  logic [1:0]      status_q, status_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;

  logic            key_valid, key_hold, key_ok;
  logic [3:0]      key_code_w;
  logic            blocked, key_none;

  vend_key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CntW)
  ) u_debounce (
    .clk_i      (clock_in),
    .rst_i      (reset_in),
    .run_i      (state_q == StDebounce),
    .col_i      (coluna_in),
    .row_i      (linha_in),
    .key_valid_o(key_valid),
    .key_hold_o (key_hold),
    .key_ok_o   (key_ok),
    .code_o     (key_code_w)
  );

  assign blocked  = !sensor1_in || !sensor2_in;
  assign key_none = (coluna_in == 3'b000) && (linha_in == 3'b000);

  // Next-state, counters and registered-output values derived from the next state.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    sense_d = '0;
    hold_d  = '0;
    sel_d   = sel_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_valid) state_d = StDebounce;
      end
      StDebounce: begin
        if (!key_hold) begin
          state_d = StIdle;
        end else if (key_ok) begin
          state_d = StArm;
          sel_d   = key_code_w;
        end
      end
      StArm: begin
        state_d = blocked ? StFault : StDispense;
      end
      StDispense: begin
        tmo_d = (tmo_q == CntW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;
        if (blocked) begin
          sense_d = (sense_q == CntW'(SENSE_CYC)) ? sense_q : sense_q + 1'b1;
        end
        // A drop seen on the same cycle as the timeout takes priority.
        if (sense_d >= CntW'(SENSE_CYC)) begin
          state_d = StRelease;
          done_d  = 1'b1;
        end else if (tmo_d >= CntW'(TIMEOUT_CYC)) begin
          state_d = StFault;
        end
      end
      StRelease: begin
        if (key_none && !blocked) begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      StFault: begin
        hold_d = (hold_q == CntW'(FAULT_HOLD)) ? hold_q : hold_q + 1'b1;
        if ((hold_d >= CntW'(FAULT_HOLD)) && key_none) begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    rele_d  = (state_d == StDispense);
    fault_d = (state_d == StFault);
    case (state_d)
      StIdle:    status_d = StatusIdle;
      StRelease: status_d = StatusDone;
      StFault:   status_d = StatusFault;
      default:   status_d = StatusBusy;
    endcase
  end

  // State, counter and output registers; reset drops the relay on the same edge.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= StIdle;
      tmo_q    <= '0;
      sense_q  <= '0;
      hold_q   <= '0;
      rele_q   <= 1'b0;
      sel_q    <= '0;
      status_q <= StatusIdle;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      sense_q  <= sense_d;
      hold_q   <= hold_d;
      rele_q   <= rele_d;
      sel_q    <= sel_d;
      status_q <= status_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  assign rele_out     = rele_q;
  assign sel_code_out = sel_q;
  assign status_out   = status_q;
  assign done_out     = done_q;
  assign fault_out    = fault_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed and randomized vends against a rule-level model.
module tb_vend_dispense_ctrl;

  localparam int Deb   = 8;
  localparam int Sense = 4;
  localparam int Tmo   = 2000;
  localparam int Hold  = 500;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic [2:0] coluna_in, linha_in;
  logic       sensor1_in, sensor2_in;
  logic       rele_out;
  logic [3:0] sel_code_out;
  logic [1:0] status_out;
  logic       done_out, fault_out;

  int n_checks = 0;
  int n_fail   = 0;

  vend_dispense_ctrl dut (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .coluna_in   (coluna_in),
    .linha_in    (linha_in),
    .sensor1_in  (sensor1_in),
    .sensor2_in  (sensor2_in),
    .rele_out    (rele_out),
    .sel_code_out(sel_code_out),
    .status_out  (status_out),
    .done_out    (done_out),
    .fault_out   (fault_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: keypad decode and vend outcome from the rules, not from any state machine.
  function automatic int oh_pos(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int exp_code(input logic [2:0] col, input logic [2:0] row);
    return oh_pos(row) * 3 + oh_pos(col) + 1;
  endfunction

  function automatic bit exp_drop(input int d, input int len);
    return (len >= Sense) && (d + Sense <= Tmo);
  endfunction

  function automatic int exp_on_cycles(input int d, input int len);
    return exp_drop(d, len) ? d + Sense : Tmo;
  endfunction

  task automatic set_sensors(input bit blk, input int which);
    sensor1_in = !(blk && which != 1);
    sensor2_in = !(blk && which != 0);
  endtask

  // Full vend: key held until relay on; sensors blocked for len samples starting d after relay-on.
  task automatic vend(input logic [2:0] col, input logic [2:0] row, input int d, input int len,
                      input int which);
    int lat, on, k, bad, n;
    coluna_in = col;
    linha_in  = row;
    set_sensors(1'b0, which);
    lat = 0;
    while (rele_out !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk("latency", lat, Deb + 2);
    chk("code", sel_code_out, exp_code(col, row));
    chk("busy_status", status_out, 2'b01);
    coluna_in = 3'b000;
    linha_in  = 3'b000;
    on = 1;
    k  = 0;
    while (rele_out === 1'b1 && k < Tmo + 100) begin
      set_sensors(k >= d && k < d + len, which);
      step();
      k++;
      if (rele_out === 1'b1) on++;
    end
    chk("relay_on_cycles", on, exp_on_cycles(d, len));
    if (exp_drop(d, len)) begin
      chk("done_pulse", done_out, 1'b1);
      chk("done_status", status_out, 2'b10);
      bad = 0;
      while (k < d + len) begin
        set_sensors(1'b1, which);
        step();
        k++;
        if (status_out !== 2'b10 || done_out !== 1'b0) bad++;
      end
      set_sensors(1'b0, which);
      step();
      chk("release_wait", bad, 0);
      chk("done_single", done_out, 1'b0);
      chk("release_status", status_out, 2'b00);
      chk("release_code", sel_code_out, 4'd0);
    end else begin
      set_sensors(1'b0, which);
      chk("timeout_fault", fault_out, 1'b1);
      chk("timeout_status", status_out, 2'b11);
      chk("timeout_nodone", done_out, 1'b0);
      chk("fault_code", sel_code_out, exp_code(col, row));
      n = 1;
      while (fault_out === 1'b1 && n < Hold + 100) begin
        step();
        if (fault_out === 1'b1) n++;
      end
      chk("fault_hold", n, Hold);
      chk("post_fault_status", status_out, 2'b00);
      chk("post_fault_code", sel_code_out, 4'd0);
    end
    step();
  endtask

  initial begin
    int bad, n, rele_seen;
    logic [2:0] c, r;
    int d, len, which;

    // Reset held with a key pressed: everything stays zero.
    reset_in   = 1'b1;
    coluna_in  = 3'b010;
    linha_in   = 3'b100;
    sensor1_in = 1'b1;
    sensor2_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({rele_out, sel_code_out, status_out, done_out, fault_out} !== 9'd0) bad++;
    end
    chk("reset_outputs", bad, 0);
    reset_in = 1'b0;

    // Key 010/100 -> code 8, six blocked cycles, drop confirmed.
    vend(3'b010, 3'b100, 0, 6, 2);

    // Key 001/001, sensors clear -> timeout fault.
    vend(3'b001, 3'b001, 0, 0, 0);

    // Bounce: 5 cycles, one empty cycle, then a full run; acceptance restarts.
    coluna_in = 3'b001;
    linha_in  = 3'b010;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rele_out !== 1'b0 || sel_code_out !== 4'd0) bad++;
    end
    coluna_in = 3'b000;
    linha_in  = 3'b000;
    step();
    if (rele_out !== 1'b0 || sel_code_out !== 4'd0 || status_out !== 2'b00) bad++;
    chk("bounce_no_accept", bad, 0);
    vend(3'b001, 3'b010, 3, 4, 0);

    // Two columns pressed: invalid, never leaves idle.
    coluna_in = 3'b011;
    linha_in  = 3'b001;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rele_out !== 1'b0 || status_out !== 2'b00) bad++;
    end
    chk("invalid_key_idle", bad, 0);
    coluna_in = 3'b000;
    linha_in  = 3'b000;
    step();

    // Drop and timeout on the same cycle: drop wins.
    vend(3'b100, 3'b010, Tmo - Sense, Sense, 1);

    // Jam: sensor1 blocked before acceptance -> fault from ARM, relay never on.
    sensor1_in = 1'b0;
    sensor2_in = 1'b1;
    coluna_in  = 3'b100;
    linha_in   = 3'b001;
    n = 0;
    rele_seen = 0;
    while (status_out !== 2'b11 && n < 100) begin
      step();
      n++;
      if (rele_out !== 1'b0) rele_seen++;
    end
    chk("jam_latency", n, Deb + 2);
    chk("jam_code", sel_code_out, exp_code(3'b100, 3'b001));
    coluna_in  = 3'b000;
    linha_in   = 3'b000;
    sensor1_in = 1'b1;
    n = 1;
    while (fault_out === 1'b1 && n < Hold + 100) begin
      step();
      if (rele_out !== 1'b0) rele_seen++;
      if (fault_out === 1'b1) n++;
    end
    chk("jam_relay_never", rele_seen, 0);
    chk("jam_hold", n, Hold);
    step();

    // Reset pulsed during dispense: relay drops on that edge.
    coluna_in = 3'b001;
    linha_in  = 3'b100;
    n = 0;
    while (rele_out !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("mid_reset_relay_on", rele_out, 1'b1);
    coluna_in = 3'b000;
    linha_in  = 3'b000;
    repeat ($urandom_range(1, 20)) step();
    reset_in = 1'b1;
    step();
    chk("mid_reset_relay", rele_out, 1'b0);
    chk("mid_reset_status", status_out, 2'b00);
    chk("mid_reset_code", sel_code_out, 4'd0);
    reset_in = 1'b0;
    step();

    // Randomized vends.
    for (int it = 0; it < 5; it++) begin
      c = 3'b001 << $urandom_range(0, 2);
      r = 3'b001 << $urandom_range(0, 2);
      d = int'($urandom_range(0, 20));
      len = int'($urandom_range(1, 8));
      which = int'($urandom_range(0, 2));
      vend(c, r, d, len, which);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
